// File: rtl/serializer_pkg.sv
// Shared definitions for the parallel-to-serial converter: default widths,
// FSM state encoding and the smallest bit count a request may carry.
package serializer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int MOD_W_DEF  = 4;

  // Requests asking for 1 or 2 bits are dropped; 0 encodes a full word.
  localparam int MOD_MIN    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter. A qualified request loads a word and emits
// its top N bits MSB first, one per cycle, starting the cycle after the
// request is taken. All outputs come straight from flops.
module serializer
  import serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MOD_W  = MOD_W_DEF
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  // One extra bit so a full DATA_W count is representable without wrapping.
  localparam int CNT_W = MOD_W + 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  sreg;
  logic               legal;
  logic               accept;

  // Number of bits requested; a zero field stands for a whole word.
  function automatic logic [CNT_W-1:0] bit_count(input logic [MOD_W-1:0] mod);
    if (mod == '0) begin
      bit_count = CNT_W'(DATA_W);
    end else begin
      bit_count = {1'b0, mod};
    end
  endfunction

  // Bit counts of 1 and 2 are rejected outright.
  function automatic logic mod_legal(input logic [MOD_W-1:0] mod);
    mod_legal = (mod == '0) || (mod >= MOD_W'(MOD_MIN));
  endfunction

  assign legal  = mod_legal(data_mod_i);
  assign accept = data_val_i && !busy_o && legal;

  // Shift register holds the bits still to be sent; the MSB of the loaded
  // word goes straight to the output flop, so the register is preloaded
  // one position ahead. Data only, so no reset.
  always_ff @(posedge clk_i) begin
    if (accept && (state == IDLE)) begin
      sreg <= data_i << 1;
    end else if (state == SHIFT) begin
      sreg <= sreg << 1;
    end
  end

  // Control FSM: counter tracks bits remaining after the one on the output.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state          <= IDLE;
      cnt            <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= SHIFT;
            cnt            <= bit_count(data_mod_i) - CNT_W'(1);
            ser_data_o     <= data_i[DATA_W-1];
            ser_data_val_o <= 1'b1;
            busy_o         <= 1'b1;
          end else begin
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            state          <= IDLE;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
          end else begin
            cnt            <= cnt - CNT_W'(1);
            ser_data_o     <= sreg[DATA_W-1];
            ser_data_val_o <= 1'b1;
            busy_o         <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          cnt            <= '0;
          ser_data_o     <= 1'b0;
          ser_data_val_o <= 1'b0;
          busy_o         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for the serializer: expected bit sequences are written out
// by hand and compared cycle by cycle against the serial output.
module tb_serializer;

  logic        clk_i;
  logic        srst_n_i;
  logic [15:0] data_i;
  logic [3:0]  data_mod_i;
  logic        data_val_i;
  logic        ser_data_o;
  logic        ser_data_val_o;
  logic        busy_o;

  int n_vec;
  int n_bad;

  serializer dut (
    .clk_i          (clk_i),
    .srst_n_i       (srst_n_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".val"},  {31'd0, ser_data_val_o}, 32'd0);
    check({tag, ".busy"}, {31'd0, busy_o},         32'd0);
    check({tag, ".bit"},  {31'd0, ser_data_o},     32'd0);
  endtask

  // exp holds the expected sequence left-aligned: bit 15-k appears at cycle k.
  task automatic check_burst(input string tag, input logic [15:0] exp, input int n);
    logic [15:0] e;
    e = exp;
    for (int k = 0; k < n; k++) begin
      check({tag, ".val"},  {31'd0, ser_data_val_o}, 32'd1);
      check({tag, ".busy"}, {31'd0, busy_o},         32'd1);
      check({tag, ".bit"},  {31'd0, ser_data_o},     {31'd0, e[15-k]});
      step();
    end
  endtask

  task automatic send(input string tag, input logic [15:0] d, input logic [3:0] m,
                      input logic [15:0] exp, input int n);
    data_i     = d;
    data_mod_i = m;
    data_val_i = 1'b1;
    step();
    data_val_i = 1'b0;
    check_burst(tag, exp, n);
    check_idle({tag, ".end"});
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    srst_n_i   = 1'b0;
    data_i     = 16'h0;
    data_mod_i = 4'd0;
    data_val_i = 1'b0;

    // Reset with a request pending: reset must win.
    step();
    data_i     = 16'hA5C3;
    data_val_i = 1'b1;
    step();
    check_idle("rst");
    step();
    check_idle("rst_prio");

    // Release with the request still up: accepted on the first cycle out.
    srst_n_i = 1'b1;
    send("full", 16'hA5C3, 4'd0, 16'b1010_0101_1100_0011, 16);

    // Partial word.
    send("part", 16'hF000, 4'd5, 16'b11110_000_0000_0000, 5);
    step();
    check_idle("part.after");

    // Illegal bit counts are dropped.
    data_i     = 16'hFFFF;
    data_mod_i = 4'd1;
    data_val_i = 1'b1;
    step();
    check_idle("mod1.a");
    step();
    check_idle("mod1.b");
    data_mod_i = 4'd2;
    step();
    check_idle("mod2.a");
    step();
    check_idle("mod2.b");
    data_val_i = 1'b0;
    step();
    send("mod3", 16'h8000, 4'd3, 16'b100_0_0000_0000_0000, 3);

    // Request while busy, plus input churn during the shift.
    data_i     = 16'h0000;
    data_mod_i = 4'd0;
    data_val_i = 1'b1;
    step();
    data_val_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("busy_req.val", {31'd0, ser_data_val_o}, 32'd1);
      check("busy_req.bit", {31'd0, ser_data_o},     32'd0);
      if (k == 2) begin
        data_i     = 16'hFFFF;
        data_mod_i = 4'd0;
        data_val_i = 1'b1;
      end
      if (k == 6) data_mod_i = 4'd3;
      if (k == 9) data_val_i = 1'b0;
      step();
    end
    check_idle("busy_req.end");
    step();
    check_idle("busy_req.never");

    // Reset in the middle of a transfer.
    data_i     = 16'hFFFF;
    data_mod_i = 4'd0;
    data_val_i = 1'b1;
    step();
    data_val_i = 1'b0;
    check_burst("mid", 16'hFFFF, 3);
    check("mid.bit4", {31'd0, ser_data_o}, 32'd1);
    srst_n_i = 1'b0;
    step();
    check_idle("mid.rst");
    srst_n_i = 1'b1;
    step();
    check_idle("mid.noresume.a");
    step();
    check_idle("mid.noresume.b");
    send("post_rst", 16'h8001, 4'd0, 16'h8001, 16);

    // Back-to-back with the strobe held high.
    data_i     = 16'h1234;
    data_mod_i = 4'd0;
    data_val_i = 1'b1;
    step();
    data_i = 16'hABCD;
    check_burst("b2b.w0", 16'h1234, 16);
    check_idle("b2b.gap");
    step();
    data_val_i = 1'b0;
    check_burst("b2b.w1", 16'hABCD, 16);
    check_idle("b2b.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, parallel word width in bits.
REQ-002 SHALL have parameter MOD_W, default 4, width of the bit-count field, equal to $clog2(DATA_W).
REQ-003 SHALL have clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have srst_n_i, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have data_i, input, DATA_W, parallel word to transmit.
REQ-006 SHALL have data_mod_i, input, MOD_W, number of valid bits; 0 means DATA_W.
REQ-007 SHALL have data_val_i, input, 1, request strobe qualifying data_i and data_mod_i.
REQ-008 SHALL have ser_data_o, output, 1, serial bit, MSB first.
REQ-009 SHALL have ser_data_val_o, output, 1, ser_data_o valid.
REQ-010 SHALL have busy_o, output, 1, transfer in progress; requests ignored.

Function
REQ-011 SHALL implement FSM states IDLE and SHIFT: IDLE->SHIFT on accepted request, SHIFT->IDLE after the last bit cycle.
REQ-012 SHALL accept a request only when data_val_i=1 and busy_o=0 in the same cycle, and capture data_i and data_mod_i into internal registers.
REQ-013 SHALL compute bit count N = DATA_W when data_mod_i=0, else N = data_mod_i.
REQ-014 SHALL drop requests with data_mod_i of 1 or 2: no capture, no output, busy_o stays 0, FSM stays IDLE.
REQ-015 SHALL drive the first bit (captured data_i[DATA_W-1]) in the cycle after acceptance, for one cycle of latency.
REQ-016 SHALL emit bits data_i[DATA_W-1] down to data_i[DATA_W-N] on N consecutive cycles, with ser_data_val_o=1 on exactly those cycles.
REQ-017 SHALL hold busy_o=1 on exactly the N output cycles and 0 otherwise, so back-to-back words are separated by exactly one idle cycle.
REQ-018 SHALL ignore data_val_i while busy_o=1 with no effect on the transfer in flight; changes on data_i and data_mod_i during SHIFT SHALL also have no effect.
REQ-019 SHALL drive ser_data_o=0 whenever ser_data_val_o=0.
REQ-020 SHALL use a MOD_W+1-bit bit counter that never wraps, so N=DATA_W terminates correctly.
REQ-021 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-022 SHALL, on srst_n_i=0 at a clock edge, set state=IDLE, counter=0, ser_data_o=0, ser_data_val_o=0 and busy_o=0.
REQ-023 SHALL abort any transfer in progress on reset, emit no further bits of it, and not resume after release.
REQ-024 SHALL accept a request in the first cycle after srst_n_i returns to 1.
REQ-025 SHALL give reset priority over data_val_i in the same cycle.

Structure
REQ-026 SHALL place DATA_W and MOD_W defaults, the IDLE/SHIFT state enum typedef, and the minimum-valid-mod constant (3) in package serializer_pkg.
REQ-027 SHALL be a single module with no sub-module; the FSM, counter and shift register are small enough to keep inline.

Verification
REQ-028 SHALL cover full word: data_i=16'hA5C3, mod=0 -> 16 valid cycles, bits 1010_0101_1100_0011, busy_o high for 16 cycles.
REQ-029 SHALL cover partial word: data_i=16'hF000, mod=5 -> 5 valid cycles, bits 1,1,1,1,0, then valid=0 and busy=0.
REQ-030 SHALL cover illegal mod: mod=1, then mod=2, any data -> no ser_data_val_o, busy_o stays 0; a next request with mod=3 and data_i=16'h8000 -> bits 1,0,0.
REQ-031 SHALL cover request while busy: second strobe (16'hFFFF, mod=0) during the 16'h0000 transfer -> output all zeros for 16 cycles, second word never sent.
REQ-032 SHALL cover mid-transfer reset: srst_n_i=0 on the 4th bit of 16'hFFFF -> valid=0 and busy=0 the next cycle; a request 16'h8001, mod=0 after release -> correct 16 bits.
REQ-033 SHALL cover back-to-back: data_val_i held high with 16'h1234 then 16'hABCD -> exactly one idle cycle between the two 16-bit bursts, both words correct.
